// File: rtl/snn_config_loader_if.sv
// rtl/snn_config_loader_if.sv - SPI pin bundle between a config host and snn_config_loader
interface snn_config_loader_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sclk, output spi_cs_n, output spi_mosi, input spi_miso);
  modport slave  (input spi_sclk, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/snn_config_loader.sv
// rtl/snn_config_loader.sv - SPI-fed shadow register file with atomic commit to the SNN config buses
// Optional shadow readback on spi_miso is compiled in with `define SNN_CFG_READBACK_EN.
module snn_config_loader #(
  parameter int NUM_BYTES   = 75,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  snn_config_loader_if.slave spi,
  output logic [383:0]       weights,
  output logic [191:0]       delays,
  output logic [7:0]         threshold,
  output logic [7:0]         decay,
  output logic [7:0]         refractory_period,
  output logic               cfg_valid,
  output logic               cfg_update
);
  localparam logic [7:0] NB = 8'(NUM_BYTES);

`ifdef SNN_CFG_READBACK_EN
  typedef enum logic [1:0] {IDLE, ADDR, DATA, READ} state_e;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
`endif

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise, cs_rise;

  state_e      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        wr_pend_q, wr_pend_d;
  logic [7:0]  wr_byte_q, wr_byte_d;
  logic        frame_wr_q, frame_wr_d;
  logic        cfg_valid_q, cfg_update_q;
  logic        commit, addr_in_range;

  logic [7:0]  shadow_q [NUM_BYTES];
  logic [7:0]  active_q [NUM_BYTES];

`ifdef SNN_CFG_READBACK_EN
  logic        sclk_fall;
  logic [7:0]  rd_shift_q, rd_shift_d;
  logic        rd_reload_q, rd_reload_d;

  function automatic logic [7:0] rd_byte(input logic [6:0] a);
    rd_byte = ({1'b0, a} < NB) ? shadow_q[a] : 8'h00;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s        = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s          = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s        = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise     = sclk_s & ~sclk_prev_q;
  assign cs_rise       = cs_s & ~cs_prev_q;
  assign addr_in_range = ({1'b0, addr_q} < NB);
`ifdef SNN_CFG_READBACK_EN
  assign sclk_fall     = ~sclk_s & sclk_prev_q;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    wr_pend_d  = 1'b0;
    wr_byte_d  = wr_byte_q;
    frame_wr_d = frame_wr_q;
    commit     = 1'b0;
`ifdef SNN_CFG_READBACK_EN
    rd_shift_d  = rd_shift_q;
    rd_reload_d = rd_reload_q;
`endif
    // Completion of a data byte: the shadow write lands this cycle, then the address advances.
    if (wr_pend_q) begin
      if (addr_in_range) frame_wr_d = 1'b1;
      if (addr_q != 7'h7f) addr_d = addr_q + 7'd1;
    end
    if (cs_s) bit_cnt_d = '0;
    if (cs_rise) begin
      state_d    = IDLE;
      commit     = frame_wr_q;
      frame_wr_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!cs_s) state_d = ADDR;
        ADDR, DATA: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                addr_d  = shift_d[6:0];
                state_d = DATA;
`ifdef SNN_CFG_READBACK_EN
                if (shift_d[7]) begin
                  state_d     = READ;
                  rd_shift_d  = rd_byte(shift_d[6:0]);
                  rd_reload_d = 1'b0;
                end
`endif
              end else begin
                wr_pend_d = 1'b1;
                wr_byte_d = shift_d;
              end
            end
          end
        end
`ifdef SNN_CFG_READBACK_EN
        READ: begin
          // The fall that ends the address byte arrives with bit_cnt == 0 and is ignored.
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (addr_q != 7'h7f) addr_d = addr_q + 7'd1;
              rd_reload_d = 1'b1;
            end
          end else if (sclk_fall) begin
            if (rd_reload_q) begin
              rd_shift_d  = rd_byte(addr_q);
              rd_reload_d = 1'b0;
            end else if (bit_cnt_q != 3'd0) begin
              rd_shift_d = {rd_shift_q[6:0], 1'b0};
            end
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      wr_pend_q    <= 1'b0;
      wr_byte_q    <= '0;
      frame_wr_q   <= 1'b0;
      cfg_valid_q  <= 1'b0;
      cfg_update_q <= 1'b0;
`ifdef SNN_CFG_READBACK_EN
      rd_shift_q   <= '0;
      rd_reload_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      wr_pend_q    <= wr_pend_d;
      wr_byte_q    <= wr_byte_d;
      frame_wr_q   <= frame_wr_d;
      cfg_update_q <= commit;
      if (commit) cfg_valid_q <= 1'b1;
`ifdef SNN_CFG_READBACK_EN
      rd_shift_q   <= rd_shift_d;
      rd_reload_q  <= rd_reload_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wr_pend_q && addr_in_range) shadow_q[addr_q] <= wr_byte_q;
      if (commit) active_q <= shadow_q;
    end
  end

  always_comb begin
    weights = '0;
    delays  = '0;
    for (int k = 0; k < 48; k++) weights[8*k +: 8] = active_q[k];
    for (int j = 0; j < 24; j++) delays[8*j +: 8]  = active_q[48+j];
  end

  assign threshold         = active_q[72];
  assign decay             = active_q[73];
  assign refractory_period = active_q[74];
  assign cfg_valid         = cfg_valid_q;
  assign cfg_update        = cfg_update_q;

`ifdef SNN_CFG_READBACK_EN
  assign spi.spi_miso = (state_q == READ) ? rd_shift_q[7] : 1'b0;
`else
  assign spi.spi_miso = 1'b0;
`endif
endmodule
